// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage and data memory.
// The MEM stage uses the master modport and data memory uses the slave modport.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses with a bounded wait, resolves
// branch/jump redirect, and drives the MEM/WB pipeline register (negedge clocked).
module mem_access_stage #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              MemWr,
  input  logic              MemtoReg,
  input  logic              Regwr,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              zero,
  input  logic [DATA_W-1:0] busB,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [DATA_W-1:0] Target,
  input  logic [DATA_W-1:0] Rd,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] PCTarget,
  mem_access_stage_if.master dmem,
  output logic              wb_Regwr,
  output logic              wb_MemtoReg,
  output logic [4:0]        wb_Rd,
  output logic [DATA_W-1:0] wb_ALUout,
  output logic [DATA_W-1:0] wb_MemData,
  output logic              mem_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [DATA_W-1:0] buf_reg, buf_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wb_regwr_reg, wb_regwr_next;
  logic              wb_memtoreg_reg, wb_memtoreg_next;
  logic [4:0]        wb_rd_reg, wb_rd_next;
  logic [DATA_W-1:0] wb_alu_reg, wb_alu_next;
  logic [DATA_W-1:0] wb_mdata_reg, wb_mdata_next;
  logic              err_reg, err_next;
  logic              memop;
  logic              unused_rd_hi;

  assign memop        = MemWr | MemtoReg;
  assign unused_rd_hi = ^Rd[DATA_W-1:5];

  always_ff @(negedge CLK) begin
    if (!Resetn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      buf_reg         <= '0;
      req_reg         <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wb_regwr_reg    <= 1'b0;
      wb_memtoreg_reg <= 1'b0;
      wb_rd_reg       <= '0;
      wb_alu_reg      <= '0;
      wb_mdata_reg    <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      buf_reg         <= buf_next;
      req_reg         <= req_next;
      we_reg          <= we_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wb_regwr_reg    <= wb_regwr_next;
      wb_memtoreg_reg <= wb_memtoreg_next;
      wb_rd_reg       <= wb_rd_next;
      wb_alu_reg      <= wb_alu_next;
      wb_mdata_reg    <= wb_mdata_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    buf_next         = buf_reg;
    req_next         = req_reg;
    we_next          = we_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wb_regwr_next    = wb_regwr_reg;
    wb_memtoreg_next = wb_memtoreg_reg;
    wb_rd_next       = wb_rd_reg;
    wb_alu_next      = wb_alu_reg;
    wb_mdata_next    = wb_mdata_reg;
    err_next         = err_reg;
    stall            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (memop) begin
          stall            = 1'b1;
          req_next         = 1'b1;
          we_next          = MemWr;
          addr_next        = ALUout;
          wdata_next       = busB;
          cnt_next         = '0;
          wb_regwr_next    = 1'b0;
          wb_memtoreg_next = 1'b0;
          state_next       = BUSY;
        end else begin
          wb_regwr_next    = Regwr;
          wb_memtoreg_next = MemtoReg;
          wb_rd_next       = Rd[4:0];
          wb_alu_next      = ALUout;
        end
      end
      BUSY: begin
        stall            = 1'b1;
        wb_regwr_next    = 1'b0;
        wb_memtoreg_next = 1'b0;
        if (dmem.dmem_ready) begin
          req_next   = 1'b0;
          buf_next   = dmem.dmem_rdata;
          state_next = DONE;
        end else if (cnt_reg == LAST_WAIT) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        // EX/MEM still holds the memory instruction here; upstream advances on this edge.
        wb_regwr_next    = Regwr;
        wb_memtoreg_next = MemtoReg;
        wb_rd_next       = Rd[4:0];
        wb_alu_next      = ALUout;
        wb_mdata_next    = buf_reg;
        state_next       = IDLE;
      end
      default: begin
        stall            = 1'b1;
        wb_regwr_next    = 1'b0;
        wb_memtoreg_next = 1'b0;
      end
    endcase
  end

  assign PCSrc           = ((Branch & zero) | Jump) & ~stall;
  assign PCTarget        = Target;
  assign dmem.dmem_req   = req_reg;
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_wdata = wdata_reg;
  assign wb_Regwr        = wb_regwr_reg;
  assign wb_MemtoReg     = wb_memtoreg_reg;
  assign wb_Rd           = wb_rd_reg;
  assign wb_ALUout       = wb_alu_reg;
  assign wb_MemData      = wb_mdata_reg;
  assign mem_err         = err_reg;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Consumer side of the EX/MEM pipeline register: the MEM stage that takes the EX/MEM control and data fields, runs a req/ready handshake to data memory, resolves branch/jump redirect, and drives the MEM/WB pipeline register. It holds the front of the pipe with a stall while a memory access is outstanding, and it flags a sticky error on memory timeout.

## Interface
- DATA_W, 32, data and address width
- MAX_WAIT, 16, memory-ready timeout in cycles; legal range ≥1
- CLK  in  1  clock; all state updates on the falling edge (negedge), same as the other pipeline registers
- Resetn  in  1  reset, synchronous, active-low
- MemWr, MemtoReg, Regwr, Branch, Jump  in  1 each  EX/MEM control fields
- zero  in  1  ALU zero flag
- busB, ALUout, Target, Rd  in  DATA_W each  EX/MEM data fields; only Rd[4:0] is used
- stall  out  1  hold EX/MEM and earlier stages
- PCSrc  out  1  redirect fetch to PCTarget
- PCTarget  out  DATA_W  equals Target
- dmem_req, dmem_we  out  1 each  memory request and write enable
- dmem_addr, dmem_wdata  out  DATA_W each  memory address and write data
- dmem_ready  in  1  memory completes the access
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1
- wb_Regwr, wb_MemtoReg  out  1 each  MEM/WB control fields
- wb_Rd  out  5  MEM/WB destination register
- wb_ALUout, wb_MemData  out  DATA_W each  MEM/WB data fields
- mem_err  out  1  sticky timeout flag

## Operation
- memop = MemWr | MemtoReg. If both are 1, the access is a write (dmem_we=1).
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE, memop=0: stall=0. Each edge, MEM/WB loads {Regwr, MemtoReg, Rd[4:0], ALUout}. wb_MemData holds its value.
- IDLE, memop=1: stall=1 (combinational). At the edge: dmem_req←1, dmem_we←MemWr, dmem_addr←ALUout, dmem_wdata←busB, wait counter←0, MEM/WB loads a bubble (wb_Regwr=0, wb_MemtoReg=0), go to BUSY.
- BUSY: stall=1. MEM/WB loads a bubble each edge.
  - If dmem_ready=1: dmem_req←0, an internal buffer captures dmem_rdata, go to DONE.
  - Otherwise, if counter = MAX_WAIT−1: dmem_req←0, mem_err←1, go to ERR.
  - Otherwise, counter increments.
- DONE: stall=0. At the edge, MEM/WB loads {Regwr, MemtoReg, Rd[4:0], ALUout, buffered rdata}. Upstream advances on the same edge. Go to IDLE.
- ERR: stall=1, dmem_req=0, MEM/WB bubbles. The block stays here until reset.
- PCSrc = ((Branch & zero) | Jump) & ~stall. This is combinational.
- dmem_ready is sampled only in BUSY. A late or spurious ready is ignored in every other state.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, buffer 0.
- Non-memory instruction: MEM/WB updated 1 edge after it is presented.
- Memory op with ready seen on the k-th BUSY edge (k≥1): stall high for k+1 cycles; MEM/WB valid after k+2 edges.
- Reset mid-access: at the reset edge, dmem_req drops and the FSM returns to IDLE; any pending ready is discarded.
- Timeout: mem_err rises on the MAX_WAIT-th BUSY edge with no ready.

## Test plan
- Reset: drive all inputs nonzero with Resetn=0 for 2 edges -> all outputs 0, stall=0 once the inputs are idle.
- ALU op: Regwr=1, Rd=7, ALUout=0x1234 -> after 1 edge wb_Regwr=1, wb_Rd=7, wb_ALUout=0x1234; stall stays 0.
- Load, ready after 2 BUSY cycles: MemtoReg=1, ALUout=0x40, rdata=0xCAFEF00D -> dmem_addr=0x40, dmem_we=0; stall high 3 cycles; then wb_MemData=0xCAFEF00D, wb_MemtoReg=1; exactly one non-bubble MEM/WB load.
- Store with MemWr=MemtoReg=1, busB=0xAA55 -> dmem_we=1, dmem_wdata=0xAA55; wb_Regwr follows Regwr=0.
- Timeout, MAX_WAIT=4, ready never asserted -> mem_err=1 on the 4th BUSY edge; dmem_req=0; stall stays 1; a later ready has no effect.
- Redirect: Branch=1, zero=1, Target=0x100 -> PCSrc=1, PCTarget=0x100. With zero=0 -> PCSrc=0. Reset asserted during BUSY -> IDLE, dmem_req=0 next edge.
